rx_timestamp_inserter: RTL and testbench



---
 rtl/rx_timestamp_inserter.sv | 189 ++++++++++++++++++
 tb/tb_rx_timestamp_inserter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_timestamp_inserter.sv
// rx_timestamp_inserter
//   Buffers the rx packet stream and inserts one 64-bit timestamp word per packet.
//   The word sits between the module headers (ctrl != 0) and the first data word (ctrl == 0).
//   Good-frame timestamps are queued in a small FIFO and popped once per packet.
//   An empty FIFO yields MISSING_TS_VALUE instead.
// Ports:
//   clk, reset                  : single clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr/in_rdy: upstream packet stream (in_rdy registered, >= 2 free slots)
//   in_timestamp(_valid)        : timestamp push, one-cycle pulse
//   out_data/out_ctrl/out_wr    : registered output word, out_wr = valid & out_rdy
//   out_rdy                     : downstream ready
//   enable                      : 1 = insert timestamps, 0 = pass-through
//   ts_dropped_cnt              : timestamps lost to FIFO overflow (wraps)
//   ts_missing_cnt              : packets stamped with MISSING_TS_VALUE (wraps)
module rx_timestamp_inserter #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter logic [7:0]  TS_CTRL            = 8'h10,
    parameter int unsigned TS_FIFO_DEPTH_BITS = 2,
    parameter logic [63:0] MISSING_TS_VALUE   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [63:0]           in_timestamp,
    input  logic                  in_timestamp_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  enable,
    output logic [31:0]           ts_dropped_cnt,
    output logic [31:0]           ts_missing_cnt
);

    localparam int unsigned TsDepth = 1 << TS_FIFO_DEPTH_BITS;
    localparam int unsigned TsCntW  = TS_FIFO_DEPTH_BITS + 1;

    typedef enum logic [1:0] {StSop, StHdr, StIns, StData} state_e;

    state_e state_q, state_d;

    // Input word FIFO (4 entries)
    logic [DATA_WIDTH-1:0] ib_data_q [4];
    logic [CTRL_WIDTH-1:0] ib_ctrl_q [4];
    logic [1:0]            ib_rd_q, ib_wr_q;
    logic [2:0]            ib_cnt_q, ib_cnt_d;
    logic                  ib_push, ib_pop, ib_empty;
    logic                  in_rdy_q;

    // Timestamp FIFO
    logic [63:0]                   ts_mem_q [TsDepth];
    logic [TS_FIFO_DEPTH_BITS-1:0] ts_rd_q, ts_wr_q;
    logic [TsCntW-1:0]             ts_cnt_q, ts_cnt_d;
    logic                          ts_pop, ts_write, ts_drop, ts_empty, ts_full;

    // Output register stage
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                  load, missing_inc;
    logic [31:0]           dropped_q, missing_q;

    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign ib_empty  = (ib_cnt_q == 3'd0);
    assign head_data = ib_data_q[ib_rd_q];
    assign head_ctrl = ib_ctrl_q[ib_rd_q];
    assign ib_push   = in_wr && (ib_cnt_q != 3'd4);
    assign ib_cnt_d  = ib_cnt_q + {2'b00, ib_push} - {2'b00, ib_pop};

    assign ts_empty = (ts_cnt_q == '0);
    assign ts_full  = (ts_cnt_q == TsCntW'(TsDepth));
    // A push into a full FIFO still lands if a pop frees a slot the same cycle.
    assign ts_write = in_timestamp_valid && (!ts_full || ts_pop);
    assign ts_drop  = in_timestamp_valid && ts_full && !ts_pop;
    assign ts_cnt_d = ts_cnt_q + TsCntW'(ts_write) - TsCntW'(ts_pop);

    // The output register refills whenever it is empty or being drained this cycle.
    assign load = !ib_empty && (!out_valid_q || out_rdy);

    always_comb begin
        state_d     = state_q;
        ib_pop      = 1'b0;
        ts_pop      = 1'b0;
        missing_inc = 1'b0;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        out_valid_d = out_valid_q && !out_rdy;
        if (load) begin
            out_valid_d = 1'b1;
            unique case (state_q)
                StSop, StHdr: begin
                    if (head_ctrl != '0) begin
                        out_data_d = head_data;
                        out_ctrl_d = head_ctrl;
                        ib_pop     = 1'b1;
                        state_d    = StHdr;
                    end else if (enable) begin
                        // Head data word stays in the FIFO; it is emitted from StIns.
                        out_ctrl_d = CTRL_WIDTH'(TS_CTRL);
                        if (ts_empty) begin
                            out_data_d  = DATA_WIDTH'(MISSING_TS_VALUE);
                            missing_inc = 1'b1;
                        end else begin
                            out_data_d = DATA_WIDTH'(ts_mem_q[ts_rd_q]);
                            ts_pop     = 1'b1;
                        end
                        state_d = StIns;
                    end else begin
                        out_data_d = head_data;
                        out_ctrl_d = head_ctrl;
                        ib_pop     = 1'b1;
                        ts_pop     = !ts_empty;
                        state_d    = StData;
                    end
                end
                StIns: begin
                    out_data_d = head_data;
                    out_ctrl_d = head_ctrl;
                    ib_pop     = 1'b1;
                    state_d    = StData;
                end
                StData: begin
                    out_data_d = head_data;
                    out_ctrl_d = head_ctrl;
                    ib_pop     = 1'b1;
                    if (head_ctrl != '0) begin
                        state_d = StSop;
                    end
                end
                default: state_d = StSop;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSop;
            ib_rd_q     <= '0;
            ib_wr_q     <= '0;
            ib_cnt_q    <= '0;
            in_rdy_q    <= 1'b0;
            ts_rd_q     <= '0;
            ts_wr_q     <= '0;
            ts_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            dropped_q   <= '0;
            missing_q   <= '0;
        end else begin
            state_q     <= state_d;
            ib_cnt_q    <= ib_cnt_d;
            in_rdy_q    <= (ib_cnt_d <= 3'd2);
            ts_cnt_q    <= ts_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            if (ib_push) ib_wr_q <= ib_wr_q + 2'd1;
            if (ib_pop) ib_rd_q <= ib_rd_q + 2'd1;
            if (ts_write) ts_wr_q <= ts_wr_q + TS_FIFO_DEPTH_BITS'(1);
            if (ts_pop) ts_rd_q <= ts_rd_q + TS_FIFO_DEPTH_BITS'(1);
            if (ts_drop) dropped_q <= dropped_q + 32'd1;
            if (missing_inc) missing_q <= missing_q + 32'd1;
        end
    end

    // Storage arrays need no reset; pointers and counts define their contents.
    always_ff @(posedge clk) begin
        if (ib_push) begin
            ib_data_q[ib_wr_q] <= in_data;
            ib_ctrl_q[ib_wr_q] <= in_ctrl;
        end
        if (ts_write) ts_mem_q[ts_wr_q] <= in_timestamp;
    end

    assign in_rdy         = in_rdy_q;
    assign out_wr         = out_valid_q && out_rdy;
    assign out_data       = out_data_q;
    assign out_ctrl       = out_ctrl_q;
    assign ts_dropped_cnt = dropped_q;
    assign ts_missing_cnt = missing_q;

endmodule

// File: tb/tb_rx_timestamp_inserter.sv
// Bench for rx_timestamp_inserter: a packet-level reference model builds the expected output
// word stream as each packet is offered, and one compare process checks every emitted word.
// Timestamps are only pushed while the model's per-packet pop order matches the DUT's.
module tb_rx_timestamp_inserter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] in_timestamp;
    logic        in_timestamp_valid;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        enable;
    logic [31:0] ts_dropped_cnt;
    logic [31:0] ts_missing_cnt;

    rx_timestamp_inserter dut (
        .clk                (clk),
        .reset              (reset),
        .in_data            (in_data),
        .in_ctrl            (in_ctrl),
        .in_wr              (in_wr),
        .in_rdy             (in_rdy),
        .in_timestamp       (in_timestamp),
        .in_timestamp_valid (in_timestamp_valid),
        .out_data           (out_data),
        .out_ctrl           (out_ctrl),
        .out_wr             (out_wr),
        .out_rdy            (out_rdy),
        .enable             (enable),
        .ts_dropped_cnt     (ts_dropped_cnt),
        .ts_missing_cnt     (ts_missing_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    word_t       exp_q[$];
    word_t       obs_q[$];
    logic [63:0] ts_model[$];
    logic [31:0] m_drop;
    logic [31:0] m_miss;
    int          vecs;
    int          fails;
    bit          chk_en;
    bit          rand_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ts(input logic [63:0] t);
        @(negedge clk);
        in_timestamp       = t;
        in_timestamp_valid = 1'b1;
        if (ts_model.size() >= 4) m_drop++;
        else ts_model.push_back(t);
        @(posedge clk);
        #1 in_timestamp_valid = 1'b0;
    endtask

    task automatic put_word(input logic [63:0] d, input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        while (!in_rdy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy) chk("in_rdy_timeout", 64'(in_rdy), 64'd1);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(posedge clk);
        #1 in_wr = 1'b0;
    endtask

    // Packet of nhdr header words then nbody data words (last one is EOP, ctrl=01).
    // When model is set, the expected output stream is appended before the words are offered.
    task automatic send_pkt(input int nhdr, input int nbody, input bit model);
        word_t w[$];
        word_t x;
        for (int i = 0; i < nhdr; i++) begin
            x.d = {$urandom, $urandom};
            x.c = 8'($urandom_range(1, 255));
            w.push_back(x);
        end
        for (int i = 0; i < nbody; i++) begin
            x.d = {$urandom, $urandom};
            x.c = (i == nbody - 1) ? 8'h01 : 8'h00;
            w.push_back(x);
        end
        if (model) begin
            for (int i = 0; i < nhdr; i++) exp_q.push_back(w[i]);
            if (enable) begin
                x.c = 8'h10;
                if (ts_model.size() > 0) begin
                    x.d = ts_model.pop_front();
                end else begin
                    x.d = 64'hFFFF_FFFF_FFFF_FFFF;
                    m_miss++;
                end
                exp_q.push_back(x);
            end else if (ts_model.size() > 0) begin
                void'(ts_model.pop_front());
            end
            for (int i = nhdr; i < nhdr + nbody; i++) exp_q.push_back(w[i]);
        end
        for (int i = 0; i < nhdr + nbody; i++) put_word(w[i].d, w[i].c);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_dropped_cnt"}, 64'(ts_dropped_cnt), 64'(m_drop));
        chk({tag, "_missing_cnt"}, 64'(ts_missing_cnt), 64'(m_miss));
    endtask

    // Downstream ready: changes just after the rising edge, stable through the sample point.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Single compare process: every emitted word is checked against the model stream.
    initial begin
        word_t e;
        word_t o;
        forever begin
            @(negedge clk);
            if (!reset && chk_en) begin
                if (!out_rdy) chk("out_wr_while_not_rdy", 64'(out_wr), 64'd0);
                if (out_wr) begin
                    o.d = out_data;
                    o.c = out_ctrl;
                    obs_q.push_back(o);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] tv[5];
        vecs = 0;
        fails = 0;
        m_drop = '0;
        m_miss = '0;
        chk_en = 1'b0;
        rand_rdy = 1'b0;
        reset = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr = 1'b0;
        in_timestamp = '0;
        in_timestamp_valid = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_dropped", 64'(ts_dropped_cnt), 64'd0);
        chk("rst_missing", 64'(ts_missing_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: one timestamp, one packet with one header and four body words.
        obs_q.delete();
        push_ts(64'h0000_0001_0000_00A0);
        send_pkt(1, 4, 1'b1);
        drain("t1");
        chk("t1_words", 64'(obs_q.size()), 64'd6);
        if (obs_q.size() == 6) begin
            chk("t1_ts_data", obs_q[1].d, 64'h0000_0001_0000_00A0);
            chk("t1_ts_ctrl", 64'(obs_q[1].c), 64'h10);
            chk("t1_last_ctrl", 64'(obs_q[5].c), 64'h01);
        end

        // 2: nothing queued -> missing value.
        obs_q.delete();
        send_pkt(2, 3, 1'b1);
        drain("t2");
        if (obs_q.size() > 2) chk("t2_missing_data", obs_q[2].d, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_missing_lit", 64'(ts_missing_cnt), 64'd1);

        // 3: overflow with five timestamps, then five packets.
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            tv[i] = {$urandom, $urandom};
            push_ts(tv[i]);
        end
        repeat (2) @(negedge clk);
        chk("t3_dropped_lit", 64'(ts_dropped_cnt), 64'd1);
        for (int i = 0; i < 5; i++) send_pkt(1, 3, 1'b1);
        drain("t3");
        if (obs_q.size() == 25) begin
            for (int i = 0; i < 4; i++) chk("t3_ts_order", obs_q[i * 5 + 1].d, tv[i]);
            chk("t3_fifth_missing", obs_q[21].d, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            chk("t3_words", 64'(obs_q.size()), 64'd25);
        end

        // 4: random backpressure, back-to-back 8-word packets, most carry a timestamp.
        rand_rdy = 1'b1;
        for (int p = 0; p < 20; p++) begin
            if ($urandom_range(0, 3) != 0) push_ts({$urandom, $urandom});
            send_pkt(2, 6, 1'b1);
        end
        drain("t4");
        rand_rdy = 1'b0;

        // 5: pass-through with two queued timestamps; they are consumed silently.
        enable = 1'b0;
        push_ts({$urandom, $urandom});
        push_ts({$urandom, $urandom});
        send_pkt(1, 4, 1'b1);
        send_pkt(1, 4, 1'b1);
        drain("t5");
        enable = 1'b1;
        obs_q.delete();
        send_pkt(1, 2, 1'b1);
        drain("t5_after");
        if (obs_q.size() > 1) chk("t5_fifo_empty", obs_q[1].d, 64'hFFFF_FFFF_FFFF_FFFF);

        // 6: reset in the middle of a packet with timestamps queued.
        for (int i = 0; i < 3; i++) push_ts({$urandom, $urandom});
        chk_en = 1'b0;
        put_word(64'h1111, 8'hFF);
        put_word(64'h2222, 8'h00);
        put_word(64'h3333, 8'h00);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        ts_model.delete();
        m_drop = '0;
        m_miss = '0;
        repeat (2) @(negedge clk);
        chk("t6_rst_out_wr", 64'(out_wr), 64'd0);
        chk("t6_rst_dropped", 64'(ts_dropped_cnt), 64'd0);
        chk("t6_rst_missing", 64'(ts_missing_cnt), 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        obs_q.delete();
        send_pkt(1, 3, 1'b1);
        drain("t6");
        if (obs_q.size() > 1) chk("t6_missing_data", obs_q[1].d, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_missing_lit", 64'(ts_missing_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
